// File: rtl/btb_predictor_if.sv
// Fetch/resolve-side bus of the branch target buffer.
// master: pipeline side (drives lookups, updates and flush, receives predictions).
// slave : the BTB itself.
interface btb_predictor_if #(
   parameter int CTR_W = 2
);
   logic             lookup_valid;
   logic [15:0]      lookup_pc;
   logic             pred_valid;
   logic             pred_hit;
   logic             pred_taken;
   logic [15:0]      pred_target;
   logic [CTR_W-1:0] pred_ctr;
   logic             upd_valid;
   logic [15:0]      upd_pc;
   logic             upd_taken;
   logic [15:0]      upd_target;
   logic             flush;

   modport master (
      output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
      input  pred_valid, pred_hit, pred_taken, pred_target, pred_ctr
   );

   modport slave (
      input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
      output pred_valid, pred_hit, pred_taken, pred_target, pred_ctr
   );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer for the lc3b fetch stage.
// Registered lookup (one-cycle latency), trained by the resolve stage,
// cleared by flush. Optional macro BTB_BYPASS_EN forwards a same-cycle
// update on the looked-up index into the prediction.
module btb_predictor #(
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   btb_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 15 - IDX_W;
   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

   function automatic logic [CTR_W-1:0] ctr_sat_inc(input logic [CTR_W-1:0] c);
      if (c == CTR_MAX) begin
         return c;
      end else begin
         return c + CTR_W'(1);
      end
   endfunction

   function automatic logic [CTR_W-1:0] ctr_sat_dec(input logic [CTR_W-1:0] c);
      if (c == {CTR_W{1'b0}}) begin
         return c;
      end else begin
         return c - CTR_W'(1);
      end
   endfunction

   // Entry storage
   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [15:0]      target_q [ENTRIES];
   logic [15:0]      target_d [ENTRIES];
   logic [CTR_W-1:0] ctr_q    [ENTRIES];
   logic [CTR_W-1:0] ctr_d    [ENTRIES];

   // Registered prediction
   logic             pred_valid_q, pred_valid_d;
   logic             pred_hit_q, pred_hit_d;
   logic             pred_taken_q, pred_taken_d;
   logic [15:0]      pred_target_q, pred_target_d;
   logic [CTR_W-1:0] pred_ctr_q, pred_ctr_d;

   logic [IDX_W-1:0] lk_idx_s, up_idx_s;
   logic [TAG_W-1:0] lk_tag_s, up_tag_s;
   logic             up_hit_s, up_we_s;
   logic             up_new_valid_s;
   logic [TAG_W-1:0] up_new_tag_s;
   logic [15:0]      up_new_target_s;
   logic [CTR_W-1:0] up_new_ctr_s;
   logic             rd_valid_s;
   logic [TAG_W-1:0] rd_tag_s;
   logic [15:0]      rd_target_s;
   logic [CTR_W-1:0] rd_ctr_s;
   logic             rd_hit_s;
   logic             unused_upd_pc0_s;

   // PC bit 0 never selects anything: instructions are word aligned.
   assign lk_idx_s         = bus.lookup_pc[IDX_W:1];
   assign lk_tag_s         = bus.lookup_pc[15:IDX_W+1];
   assign up_idx_s         = bus.upd_pc[IDX_W:1];
   assign up_tag_s         = bus.upd_pc[15:IDX_W+1];
   assign unused_upd_pc0_s = bus.upd_pc[0];
   assign up_we_s          = bus.upd_valid & ~bus.flush;

   // Post-update image of the entry addressed by the resolve stage
   always_comb begin
      up_hit_s        = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
      up_new_valid_s  = valid_q[up_idx_s];
      up_new_tag_s    = tag_q[up_idx_s];
      up_new_target_s = target_q[up_idx_s];
      up_new_ctr_s    = ctr_q[up_idx_s];
      if (up_hit_s) begin
         if (bus.upd_taken) begin
            up_new_ctr_s    = ctr_sat_inc(ctr_q[up_idx_s]);
            up_new_target_s = bus.upd_target;
         end else begin
            up_new_ctr_s    = ctr_sat_dec(ctr_q[up_idx_s]);
         end
      end else if (bus.upd_taken) begin
         up_new_valid_s  = 1'b1;
         up_new_tag_s    = up_tag_s;
         up_new_target_s = bus.upd_target;
         up_new_ctr_s    = CTR_WT;
      end else begin
         up_new_valid_s  = valid_q[up_idx_s];
      end
   end

   // Next storage state: flush wins over a same-cycle update
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (bus.flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i] = 1'b0;
         end
      end else if (up_we_s) begin
         valid_d[up_idx_s]  = up_new_valid_s;
         tag_d[up_idx_s]    = up_new_tag_s;
         target_d[up_idx_s] = up_new_target_s;
         ctr_d[up_idx_s]    = up_new_ctr_s;
      end else begin
         valid_d = valid_q;
      end
   end

   // Entry read for the lookup, optionally forwarding the same-cycle update
   always_comb begin
      rd_valid_s  = valid_q[lk_idx_s];
      rd_tag_s    = tag_q[lk_idx_s];
      rd_target_s = target_q[lk_idx_s];
      rd_ctr_s    = ctr_q[lk_idx_s];
`ifdef BTB_BYPASS_EN
      if (up_we_s && (up_idx_s == lk_idx_s)) begin
         rd_valid_s  = up_new_valid_s;
         rd_tag_s    = up_new_tag_s;
         rd_target_s = up_new_target_s;
         rd_ctr_s    = up_new_ctr_s;
      end else begin
         rd_valid_s  = valid_q[lk_idx_s];
      end
`endif
   end

   // Prediction formation; all fields zero when no lookup is requested
   always_comb begin
      pred_valid_d  = 1'b0;
      pred_hit_d    = 1'b0;
      pred_taken_d  = 1'b0;
      pred_target_d = 16'h0000;
      pred_ctr_d    = {CTR_W{1'b0}};
      rd_hit_s      = rd_valid_s && (rd_tag_s == lk_tag_s);
      if (bus.lookup_valid) begin
         pred_valid_d = 1'b1;
         pred_hit_d   = rd_hit_s;
         pred_taken_d = rd_hit_s && rd_ctr_s[CTR_W-1];
         if (pred_taken_d) begin
            pred_target_d = rd_target_s;
         end else begin
            pred_target_d = bus.lookup_pc + 16'd2;
         end
         if (rd_hit_s) begin
            pred_ctr_d = rd_ctr_s;
         end else begin
            pred_ctr_d = {CTR_W{1'b0}};
         end
      end else begin
         pred_valid_d = 1'b0;
      end
   end

   // State and output registers; reset leaves every entry weakly not-taken and invalid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= {TAG_W{1'b0}};
            target_q[i] <= 16'h0000;
            ctr_q[i]    <= CTR_WNT;
         end
         pred_valid_q  <= 1'b0;
         pred_hit_q    <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= 16'h0000;
         pred_ctr_q    <= {CTR_W{1'b0}};
      end else begin
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         target_q      <= target_d;
         ctr_q         <= ctr_d;
         pred_valid_q  <= pred_valid_d;
         pred_hit_q    <= pred_hit_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         pred_ctr_q    <= pred_ctr_d;
      end
   end

   assign bus.pred_valid  = pred_valid_q;
   assign bus.pred_hit    = pred_hit_q;
   assign bus.pred_taken  = pred_taken_q;
   assign bus.pred_target = pred_target_q;
   assign bus.pred_ctr    = pred_ctr_q;

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer for the lc3b pipeline: direct-mapped storage of tag, target and saturating direction counter per entry. Sits beside the fetch stage. It takes a registered lookup on the fetch PC, returns a prediction one cycle later, and is trained by the branch-resolve stage. It replaces the stateless prediction-decode logic with real storage, allocation, counter training and flush.

## Interface
Parameters:
- ENTRIES, 16: number of entries; power of 2, 2..256; IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, 1..4; predict taken when counter MSB = 1.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- lookup_valid, input, 1: fetch requests a prediction this cycle.
- lookup_pc, input, 16 (lc3b_word): fetch PC; bit 0 ignored.
- pred_valid, output, 1: registered; a prediction is presented this cycle.
- pred_hit, output, 1: tag matched a valid entry.
- pred_taken, output, 1: hit and counter MSB = 1.
- pred_target, output, 16: stored target if pred_taken, else lookup_pc + 2.
- pred_ctr, output, CTR_W: counter value read (0 on miss), forwarded down the pipe for training.
- upd_valid, input, 1: resolve stage reports a resolved control-flow instruction.
- upd_pc, input, 16: PC of the resolved instruction.
- upd_taken, input, 1: actual direction.
- upd_target, input, 16: actual taken target.
- flush, input, 1: invalidate all entries.

## Operation
- Index = pc[IDX_W:1]; tag = pc[15:IDX_W+1]. Each entry holds a valid bit, the tag, a 16-bit target and a CTR_W-bit counter.
- Lookup: on a clk edge with lookup_valid=1, the entry is read and all pred_* outputs are registered.
  - pred_valid=1 for exactly one cycle per accepted lookup.
  - With lookup_valid=0, pred_valid=0 and the other pred_* outputs hold 0.
- Update, tag hit:
  - Counter increments on taken, saturating at 2^CTR_W−1.
  - Counter decrements on not-taken, saturating at 0.
  - Target is overwritten with upd_target only when upd_taken=1.
- Update, tag miss or invalid entry:
  - If upd_taken=1: allocate by overwriting the entry. Set valid=1, tag, target, and counter = 2^(CTR_W−1) (weakly taken).
  - If upd_taken=0: no state change.
- Flush: all valid bits clear at the next edge.
  - Flush has priority over a same-cycle update, which is discarded.
  - A same-cycle lookup reads pre-flush state.
- Reset (asynchronous assert): all valid bits = 0, all counters = 2^(CTR_W−1)−1 (weakly not-taken), and all outputs = 0 immediately. Targets and tags are don't-care.
- Reset deasserting mid-operation: the first lookup after release misses.
- Address arithmetic is 16-bit modulo: lookup_pc = 0xFFFE yields a fall-through of 0x0000.

## Timing
- Lookup latency is 1 cycle: request at edge t, prediction valid at t+1.
- Lookups are fully pipelined, one per cycle.
- Update latency is 1 cycle: state is written at the edge where upd_valid=1 and is visible to lookups issued at the next edge.
- Same-cycle lookup and update to the same index: governed by the Configuration macro.
- No backpressure: pred_* outputs are valid for one cycle only, and the consumer must capture them.

## Configuration
- BTB_BYPASS_EN defined: a same-cycle update to the same index forwards its post-update entry (valid, tag, target, counter) into the lookup result. This includes allocation, and excludes updates discarded by flush.
- BTB_BYPASS_EN undefined: the lookup returns pre-update storage contents, and the update lands one cycle later as normal.

## Test plan
- Reset, then lookup at 0x3000 → next cycle: pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x3002, pred_ctr=0.
- Update 0x3000 taken to 0x3100, then lookup 0x3000 → pred_hit=1, pred_taken=1, pred_target=0x3100, pred_ctr=2'b10.
- Three not-taken updates on 0x3000 → counter steps 10→01→00 and stays at 00; lookup gives pred_taken=0, pred_target=0x3002. Four taken updates → saturates at 11.
- Aliasing with ENTRIES=16: 0x3000 allocated, then taken update on 0x3020 (same index) → lookup 0x3000 misses; 0x3020 hits with the new target.
- Flush and update asserted on the same edge → every subsequent lookup misses; a flush pulse after training also clears all hits.
- Same-cycle lookup and allocating update on 0x4000 → with BTB_BYPASS_EN: pred_hit=1, target forwarded; without it: pred_hit=0. Separately, reset_n asserted mid-stream clears pred_valid asynchronously.
